// File: rtl/riscv_pkg.sv
// Shared types for the writeback stage: writeback source, FSM state, load
// funct3 encodings and the instruction fields held while a write is in flight.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_NONE = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LOAD = 2'd1,
    S_COMMIT    = 2'd2
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // ALU and link values go straight into write_data on accept, so of the
  // result word only the load byte offset has to be kept.
  typedef struct packed {
    logic [4:0] rd;
    wb_sel_e    wb_sel;
    logic [2:0] funct3;
    logic [1:0] offset;
  } wb_instr_t;

  function automatic logic writes_reg(input logic [4:0] rd, input wb_sel_e sel);
    return (rd != 5'd0) && (sel != WB_NONE);
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Extracts and extends the addressed byte/half/word from an aligned load word.
module load_formatter
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  // NOTE: data gets a default before the case so no latch is inferred.
  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data = rdata;
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: accepts one instruction per cycle, waits for load data with
// a timeout, and drives a registered register-file write port.
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_result,
  input  logic [31:0] in_pc_plus4,
  input  logic [1:0]  in_wb_sel,
  input  logic [2:0]  in_funct3,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        write_enable,
  output logic [4:0]  write_address,
  output logic [31:0] write_data,
  output logic [31:0] pending_mask,
  output logic        load_timeout
);

  localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);

  wb_state_e        state_q, state_d;
  wb_instr_t        instr_q, instr_d, in_instr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_enable_q, write_enable_d;
  logic [4:0]       write_address_q, write_address_d;
  logic [31:0]      write_data_q, write_data_d;
  logic             load_timeout_q, load_timeout_d;
  logic             accept, wait_expired;
  logic [31:0]      load_data;

  assign in_instr = '{rd:     in_rd,
                      wb_sel: wb_sel_e'(in_wb_sel),
                      funct3: in_funct3,
                      offset: in_result[1:0]};

  assign in_ready     = (state_q != S_WAIT_LOAD);
  assign accept       = in_valid && in_ready;
  assign wait_expired = (cnt_q == CNT_W'(LOAD_TIMEOUT - 1));

  load_formatter u_fmt (
    .funct3 (instr_q.funct3),
    .offset (instr_q.offset),
    .rdata  (mem_rdata),
    .data   (load_data)
  );

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_COMMIT: begin
        if (!accept)                          state_d = S_IDLE;
        else if (in_instr.wb_sel == WB_LOAD)  state_d = S_WAIT_LOAD;
        else                                  state_d = S_COMMIT;
      end
      S_WAIT_LOAD: begin
        if (mem_rvalid)        state_d = S_COMMIT;
        else if (wait_expired) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the transition so they line up with
  // the cycle the FSM spends in COMMIT (or the cycle after a timeout).
  always_comb begin
    instr_d         = accept ? in_instr : instr_q;
    cnt_d           = cnt_q;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    load_timeout_d  = 1'b0;
    unique case (state_q)
      S_IDLE, S_COMMIT: begin
        if (accept) begin
          cnt_d = '0;
          if (in_instr.wb_sel != WB_LOAD && writes_reg(in_instr.rd, in_instr.wb_sel)) begin
            write_enable_d  = 1'b1;
            write_address_d = in_rd;
            write_data_d    = (in_instr.wb_sel == WB_PC4) ? in_pc_plus4 : in_result;
          end
        end
      end
      S_WAIT_LOAD: begin
        if (mem_rvalid) begin
          if (writes_reg(instr_q.rd, instr_q.wb_sel)) begin
            write_enable_d  = 1'b1;
            write_address_d = instr_q.rd;
            write_data_d    = load_data;
          end
        end else if (wait_expired) begin
          load_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q           <= '0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      load_timeout_q  <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      load_timeout_q  <= load_timeout_d;
    end
  end

  // NOTE: the captured instruction has no reset; it is only observed while
  // state_q != S_IDLE, and reset forces IDLE.
  always_ff @(posedge clock) begin
    instr_q <= instr_d;
  end

  always_comb begin
    pending_mask = '0;
    if (state_q != S_IDLE && writes_reg(instr_q.rd, instr_q.wb_sel))
      pending_mask[instr_q.rd] = 1'b1;
  end

  assign write_enable  = write_enable_q;
  assign write_address = write_address_q;
  assign write_data    = write_data_q;
  assign load_timeout  = load_timeout_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: stimulus pushes expected write/timeout
// events into a queue, a negedge monitor pops and compares them.
module tb_writeback_unit;
  import riscv_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic [31:0] in_pc_plus4;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic [31:0] pending_mask;
  logic        load_timeout;

  always #5 clock = ~clock;

  writeback_unit #(.LOAD_TIMEOUT(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_result     (in_result),
    .in_pc_plus4   (in_pc_plus4),
    .in_wb_sel     (in_wb_sel),
    .in_funct3     (in_funct3),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .pending_mask  (pending_mask),
    .load_timeout  (load_timeout)
  );

  typedef struct {
    bit         is_timeout;
    logic [4:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clock) begin
    if (write_enable === 1'b1 || load_timeout === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, load_timeout, write_enable}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_timeout) begin
          check("timeout_pulse", {30'd0, load_timeout, write_enable}, 32'd2);
        end else begin
          check("wr_enable", {31'd0, write_enable}, 32'd1);
          check("wr_addr", {27'd0, write_address}, {27'd0, e.addr});
          check("wr_data", write_data, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input logic [4:0] rd, input logic [31:0] res,
                           input logic [31:0] pc4, input logic [1:0] sel,
                           input logic [2:0] f3);
    in_valid    = 1'b1;
    in_rd       = rd;
    in_result   = res;
    in_pc_plus4 = pc4;
    in_wb_sel   = sel;
    in_funct3   = f3;
  endtask

  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{is_timeout: 1'b0, addr: a, data: d});
  endtask

  task automatic expect_timeout();
    exp_q.push_back('{is_timeout: 1'b1, addr: 5'd0, data: 32'd0});
  endtask

  task automatic load_case(input string name, input logic [4:0] rd, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] rdata,
                           input logic [31:0] expected, input int delay);
    expect_write(rd, expected);
    set_instr(rd, addr, 32'd0, WB_LOAD, f3);
    tick();
    in_valid = 1'b0;
    check({name, "_wait_ready"}, {31'd0, in_ready}, 32'd0);
    check({name, "_wait_pending"}, pending_mask, 32'd1 << rd);
    repeat (delay) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    check({name, "_commit_pending"}, pending_mask, 32'd1 << rd);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_result = '0; in_pc_plus4 = '0;
    in_wb_sel = '0; in_funct3 = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("rst_we", {31'd0, write_enable}, 32'd0);
    check("rst_addr", {27'd0, write_address}, 32'd0);
    check("rst_data", write_data, 32'd0);
    check("rst_timeout", {31'd0, load_timeout}, 32'd0);
    check("rst_pending", pending_mask, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;

    // ALU write, one-cycle latency, pending only during COMMIT
    expect_write(5'd5, 32'h0000_1234);
    set_instr(5'd5, 32'h0000_1234, 32'h0, WB_ALU, 3'd0);
    check("alu_pending_before", pending_mask, 32'd0);
    tick();
    in_valid = 1'b0;
    check("alu_pending_commit", pending_mask, 32'h0000_0020);
    tick();
    check("alu_pending_after", pending_mask, 32'd0);
    check("alu_we_after", {31'd0, write_enable}, 32'd0);

    // back-to-back ALU ops
    expect_write(5'd1, 32'h0000_000A);
    set_instr(5'd1, 32'h0000_000A, 32'h0, WB_ALU, 3'd0);
    tick();
    check("b2b_ready_1", {31'd0, in_ready}, 32'd1);
    expect_write(5'd2, 32'h0000_000B);
    set_instr(5'd2, 32'h0000_000B, 32'h0, WB_ALU, 3'd0);
    tick();
    in_valid = 1'b0;
    check("b2b_ready_2", {31'd0, in_ready}, 32'd1);
    check("b2b_we_2", {31'd0, write_enable}, 32'd1);
    tick();

    // PC4 link value, NONE and rd=0 suppress the write
    expect_write(5'd31, 32'h0000_0100);
    set_instr(5'd31, 32'h0000_DEAD, 32'h0000_0100, WB_PC4, 3'd0);
    tick();
    set_instr(5'd7, 32'h0000_0077, 32'h0, WB_NONE, 3'd0);
    tick();
    in_valid = 1'b0;
    check("none_pending", pending_mask, 32'd0);
    set_instr(5'd0, 32'h0000_0055, 32'h0, WB_ALU, 3'd0);
    tick();
    in_valid = 1'b0;
    check("rd0_pending", pending_mask, 32'd0);
    check("rd0_we", {31'd0, write_enable}, 32'd0);
    tick();

    // load formatting
    load_case("lb_off3",  5'd3,  32'h0000_1003, F3_LB,  32'h80FF_0000, 32'hFFFF_FF80, 2);
    load_case("lhu_off2", 5'd4,  32'h0000_2002, F3_LHU, 32'hBEEF_1234, 32'h0000_BEEF, 0);
    load_case("lw",       5'd6,  32'h0000_3000, F3_LW,  32'h1234_5678, 32'h1234_5678, 1);
    load_case("lh_off0",  5'd13, 32'h0000_3000, F3_LH,  32'h0000_8001, 32'hFFFF_8001, 0);
    load_case("lbu_off1", 5'd14, 32'h0000_3001, F3_LBU, 32'h0000_FF00, 32'h0000_00FF, 3);
    load_case("undef_f3", 5'd15, 32'h0000_3000, 3'b011, 32'hFFFF_FFFF, 32'h0000_0000, 0);

    // load commit overlapped with a new ALU accept
    expect_write(5'd8, 32'h0BAD_F00D);
    expect_write(5'd9, 32'h0000_0099);
    set_instr(5'd8, 32'h0000_0000, 32'h0, WB_LOAD, F3_LW);
    tick();
    in_valid   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BAD_F00D;
    tick();
    mem_rvalid = 1'b0;
    check("overlap_ready", {31'd0, in_ready}, 32'd1);
    set_instr(5'd9, 32'h0000_0099, 32'h0, WB_ALU, 3'd0);
    tick();
    in_valid = 1'b0;
    tick();

    // stray mem_rvalid in IDLE is ignored
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5A5A_5A5A;
    tick();
    mem_rvalid = 1'b0;
    check("stray_rvalid_we", {31'd0, write_enable}, 32'd0);

    // timeout after 16 silent WAIT_LOAD cycles
    expect_timeout();
    set_instr(5'd10, 32'h0000_0000, 32'h0, WB_LOAD, F3_LW);
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    check("to_last_wait_ready", {31'd0, in_ready}, 32'd0);
    check("to_last_wait_pulse", {31'd0, load_timeout}, 32'd0);
    tick();
    check("to_pulse", {31'd0, load_timeout}, 32'd1);
    check("to_ready", {31'd0, in_ready}, 32'd1);
    check("to_pending", pending_mask, 32'd0);
    tick();
    check("to_pulse_end", {31'd0, load_timeout}, 32'd0);

    // mem_rvalid on the timeout cycle wins
    expect_write(5'd11, 32'hCAFE_F00D);
    set_instr(5'd11, 32'h0000_0004, 32'h0, WB_LOAD, F3_LW);
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    check("prio_no_pulse", {31'd0, load_timeout}, 32'd0);
    tick();

    // reset while waiting for a load, then late data
    set_instr(5'd12, 32'h0000_0000, 32'h0, WB_LOAD, F3_LW);
    tick();
    in_valid = 1'b0;
    check("rstw_pending", pending_mask, 32'h0000_1000);
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_1111;
    check("rstw_addr", {27'd0, write_address}, 32'd0);
    check("rstw_data", write_data, 32'd0);
    check("rstw_pending0", pending_mask, 32'd0);
    check("rstw_ready", {31'd0, in_ready}, 32'd1);
    tick();
    mem_rvalid = 1'b0;
    check("rstw_no_write", {31'd0, write_enable}, 32'd0);
    tick();

    drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter LOAD_TIMEOUT, default 16, max WAIT_LOAD cycles before abandoning a load.
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  memory stage presents an instruction.
REQ-005 in_ready  output  1  unit can accept an instruction this cycle.
REQ-006 in_rd  input  5  destination register number.
REQ-007 in_result  input  32  ALU result / load address.
REQ-008 in_pc_plus4  input  32  link value for JAL/JALR.
REQ-009 in_wb_sel  input  2  source: 0 ALU, 1 LOAD, 2 PC4, 3 NONE.
REQ-010 in_funct3  input  3  load size/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101).
REQ-011 mem_rvalid  input  1  load data valid.
REQ-012 mem_rdata  input  32  raw aligned load word.
REQ-013 write_enable  output  1  register-file write strobe.
REQ-014 write_address  output  5  register-file write index.
REQ-015 write_data  output  32  register-file write value.
REQ-016 pending_mask  output  32  one bit per register with a write in flight.
REQ-017 load_timeout  output  1  one-cycle pulse when a load is abandoned.

Function
REQ-018 The unit SHALL implement states IDLE, WAIT_LOAD, COMMIT.
REQ-019 in_ready SHALL be 1 in IDLE and COMMIT, 0 in WAIT_LOAD; accept = in_valid && in_ready.
REQ-020 On accept the unit SHALL capture rd, result, pc_plus4, wb_sel, funct3.
REQ-021 Accept with wb_sel ALU/PC4/NONE SHALL go to COMMIT next cycle; wb_sel LOAD SHALL go to WAIT_LOAD.
REQ-022 In COMMIT, write_enable SHALL be 1 for exactly that cycle, except when rd==0 or wb_sel NONE (write_enable 0).
REQ-023 COMMIT with a simultaneous accept SHALL go to COMMIT/WAIT_LOAD per REQ-021; otherwise to IDLE (back-to-back ALU ops write every cycle).
REQ-024 ALU/PC4 latency: accept at cycle N, write_enable high at N+1.
REQ-025 In WAIT_LOAD, mem_rvalid SHALL latch formatted data and go to COMMIT next cycle; load write occurs one cycle after mem_rvalid.
REQ-026 Formatting: offset = result[1:0]; LB/LBU take byte[offset]; LH/LHU take half[offset[1]]; LW whole word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-027 Undefined load funct3 (011, 110, 111) SHALL write 0.
REQ-028 mem_rvalid outside WAIT_LOAD SHALL be ignored.
REQ-029 Cycle counter SHALL clear on entering WAIT_LOAD, increment each WAIT_LOAD cycle without mem_rvalid; reaching LOAD_TIMEOUT SHALL pulse load_timeout, skip the write, go to IDLE.
REQ-030 mem_rvalid on the timeout cycle SHALL take priority (load completes, no pulse).
REQ-031 pending_mask bit rd SHALL be 1 while the captured instruction is in WAIT_LOAD or COMMIT with a write due; bit 0 always 0.
REQ-032 All outputs except in_ready and pending_mask SHALL be registered; write_address/write_data hold last values when write_enable is 0.

Reset
REQ-033 Reset SHALL force state IDLE, counter 0, write_enable 0, write_address 0, write_data 0, load_timeout 0, pending_mask 0.
REQ-034 Reset during WAIT_LOAD or COMMIT SHALL abort with no write; a later mem_rvalid SHALL be ignored.

Structure
REQ-035 Package riscv_pkg SHALL hold the wb_sel enum, load funct3 constants and the state typedef.
REQ-036 Load formatting SHALL be a combinational sub-module load_formatter (funct3, offset, rdata -> data).

Verification
REQ-037 ALU: accept rd=5, result 0x1234 at N -> write_enable=1, addr 5, data 0x1234 at N+1; pending_mask[5]=1 only at N+1.
REQ-038 Back-to-back: rd=1 0xA then rd=2 0xB on consecutive cycles -> writes on consecutive cycles, in_ready held 1.
REQ-039 LB offset 3, rdata 0x80FF_0000 -> write 0xFFFF_FF80; LHU offset 2, rdata 0xBEEF_1234 -> 0x0000_BEEF.
REQ-040 Load, no mem_rvalid for 16 cycles -> load_timeout pulse, no write, in_ready returns to 1.
REQ-041 rd=0 with result 0x55 -> write_enable stays 0, pending_mask stays 0.
REQ-042 Reset 1 cycle in WAIT_LOAD, then mem_rvalid -> no write, all outputs 0, state IDLE.
